cache_mem_arbiter: RTL and testbench

- Shares the single cache-side memory port (rd_*/wr_* protocol, in front of the AXI bridge) between N_REQ cache read requesters and the dcache write path.
- Read arbitration is round-robin, with one read outstanding at a time.
- Return data is routed back to the granted requester only.
- Reads that hit the cache line of an in-flight write are held off until that write completes, so the read cannot return stale data.

---
 rtl/cache_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares the cache-side rd_*/wr_* memory port between N_REQ round-robin read
// requesters and the dcache write path, holding off reads that hit a pending write line.
module cache_mem_arbiter #(
  parameter int N_REQ        = 2,
  parameter int LINE_WORDS   = 8,
  parameter int OFFSET_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        u_rd_req,
  input  logic [3*N_REQ-1:0]      u_rd_type,
  input  logic [32*N_REQ-1:0]     u_rd_addr,
  output logic [N_REQ-1:0]        u_rd_rdy,
  output logic [N_REQ-1:0]        u_ret_valid,
  output logic [N_REQ-1:0]        u_ret_last,
  output logic [31:0]             u_ret_data,
  input  logic                    u_wr_req,
  input  logic [2:0]              u_wr_type,
  input  logic [31:0]             u_wr_addr,
  input  logic [3:0]              u_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] u_wr_data,
  output logic                    u_wr_rdy,
  output logic                    rd_req,
  output logic [2:0]              rd_type,
  output logic [31:0]             rd_addr,
  input  logic                    rd_rdy,
  input  logic                    ret_valid,
  input  logic                    ret_last,
  input  logic [31:0]             ret_data,
  output logic                    wr_req,
  output logic [2:0]              wr_type,
  output logic [31:0]             wr_addr,
  output logic [3:0]              wr_wstrb,
  output logic [32*LINE_WORDS-1:0] wr_data,
  input  logic                    wr_rdy,
  input  logic                    wr_done,
  output logic                    proto_err
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LW = 32 - OFFSET_WIDTH;
  localparam int CW = $clog2(LINE_WORDS + 1) + 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  rstate_e           state_q;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     rrPtr_q;
  logic [2:0]        type_q;
  logic [31:0]       addr_q;
  logic [CW-1:0]     beatCnt_q;
  logic              protoErr_q;
  logic              wrPending_q, wrPending_d;
  logic [LW-1:0]     pendLine_q, pendLine_d;

  logic              wrHs;
  logic [N_REQ-1:0]  hazard;
  logic [N_REQ-1:0]  eligible;
  logic              anyEligible;
  logic [GW-1:0]     winner;
  logic [31:0]       selAddr;
  logic [2:0]        selType;
  logic [N_REQ-1:0]  grantOneHot;
  logic [CW-1:0]     beatsSeen;
  logic [CW-1:0]     expBeats;

  // Only one write may be outstanding, so the write channel is closed while one is pending.
  assign u_wr_rdy = wr_rdy & ~wrPending_q;
  assign wrHs     = u_wr_req & u_wr_rdy;
  assign wr_req   = u_wr_req & ~wrPending_q;
  assign wr_type  = wrPending_q ? '0 : u_wr_type;
  assign wr_addr  = wrPending_q ? '0 : u_wr_addr;
  assign wr_wstrb = wrPending_q ? '0 : u_wr_wstrb;
  assign wr_data  = wrPending_q ? '0 : u_wr_data;

  always_comb begin
    wrPending_d = wrPending_q;
    pendLine_d  = pendLine_q;
    if (wrHs) begin
      wrPending_d = 1'b1;
      pendLine_d  = u_wr_addr[31:OFFSET_WIDTH];
    end else if (wr_done) begin
      wrPending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wrPending_q <= 1'b0;
      pendLine_q  <= '0;
    end else begin
      wrPending_q <= wrPending_d;
      pendLine_q  <= pendLine_d;
    end
  end

  // A write being accepted this cycle blocks same-line reads just like a pending one.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hazard[i] = (wrPending_q && (u_rd_addr[i*32+OFFSET_WIDTH +: LW] == pendLine_q)) ||
                  (wrHs && (u_rd_addr[i*32+OFFSET_WIDTH +: LW] == u_wr_addr[31:OFFSET_WIDTH]));
    end
  end

  assign eligible = u_rd_req & ~hazard;

  always_comb begin : arbitrate
    int idx;
    idx         = 0;
    winner      = '0;
    anyEligible = 1'b0;
    selAddr     = '0;
    selType     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!anyEligible && eligible[idx]) begin
        anyEligible = 1'b1;
        winner      = GW'(idx);
        selAddr     = u_rd_addr[idx*32 +: 32];
        selType     = u_rd_type[idx*3 +: 3];
      end
    end
  end

  assign grantOneHot = N_REQ'(1) << grant_q;
  assign beatsSeen   = (&beatCnt_q) ? beatCnt_q : beatCnt_q + 1'b1;
  assign expBeats    = (type_q == 3'b100) ? CW'(LINE_WORDS) : CW'(1);

  // Unsupported types are latched as word reads so the bridge only ever sees legal types.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= R_IDLE;
      grant_q    <= '0;
      rrPtr_q    <= '0;
      type_q     <= '0;
      addr_q     <= '0;
      beatCnt_q  <= '0;
      protoErr_q <= 1'b0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (anyEligible) begin
            grant_q <= winner;
            addr_q  <= selAddr;
            type_q  <= (selType == 3'b100) ? 3'b100 : 3'b010;
            rrPtr_q <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
            state_q <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (rd_rdy) begin
            beatCnt_q <= '0;
            state_q   <= R_DATA;
          end
        end
        R_DATA: begin
          if (ret_valid) begin
            beatCnt_q <= beatsSeen;
            if (ret_last) begin
              if (beatsSeen != expBeats) protoErr_q <= 1'b1;
              state_q <= R_IDLE;
            end
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign rd_req      = (state_q == R_ADDR);
  assign rd_type     = rd_req ? type_q : '0;
  assign rd_addr     = rd_req ? addr_q : '0;
  assign u_rd_rdy    = (rd_req && rd_rdy) ? grantOneHot : '0;
  assign u_ret_valid = (state_q == R_DATA && ret_valid) ? grantOneHot : '0;
  assign u_ret_last  = (state_q == R_DATA && ret_last) ? grantOneHot : '0;
  assign u_ret_data  = (state_q == R_DATA) ? ret_data : '0;
  assign proto_err   = protoErr_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, directed corner sequences
// and a randomized run against a transaction-level reference model.
module tb_cache_mem_arbiter;

  localparam int N  = 2;
  localparam int LWORDS = 8;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [N-1:0]          u_rd_req;
  logic [3*N-1:0]        u_rd_type;
  logic [32*N-1:0]       u_rd_addr;
  logic [N-1:0]          u_rd_rdy;
  logic [N-1:0]          u_ret_valid;
  logic [N-1:0]          u_ret_last;
  logic [31:0]           u_ret_data;
  logic                  u_wr_req;
  logic [2:0]            u_wr_type;
  logic [31:0]           u_wr_addr;
  logic [3:0]            u_wr_wstrb;
  logic [32*LWORDS-1:0]  u_wr_data;
  logic                  u_wr_rdy;
  logic                  rd_req;
  logic [2:0]            rd_type;
  logic [31:0]           rd_addr;
  logic                  rd_rdy;
  logic                  ret_valid;
  logic                  ret_last;
  logic [31:0]           ret_data;
  logic                  wr_req;
  logic [2:0]            wr_type;
  logic [31:0]           wr_addr;
  logic [3:0]            wr_wstrb;
  logic [32*LWORDS-1:0]  wr_data;
  logic                  wr_rdy;
  logic                  wr_done;
  logic                  proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.N_REQ(N), .LINE_WORDS(LWORDS), .OFFSET_WIDTH(5)) dut (
    .clk(clk), .resetn(resetn),
    .u_rd_req(u_rd_req), .u_rd_type(u_rd_type), .u_rd_addr(u_rd_addr), .u_rd_rdy(u_rd_rdy),
    .u_ret_valid(u_ret_valid), .u_ret_last(u_ret_last), .u_ret_data(u_ret_data),
    .u_wr_req(u_wr_req), .u_wr_type(u_wr_type), .u_wr_addr(u_wr_addr), .u_wr_wstrb(u_wr_wstrb),
    .u_wr_data(u_wr_data), .u_wr_rdy(u_wr_rdy),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_done(wr_done), .proto_err(proto_err)
  );

  // One row = one clock cycle of stimulus plus the outputs expected in that cycle.
  typedef struct packed {
    logic [1:0] rq;
    logic       rdRdy;
    logic       rv;
    logic       rl;
    logic       eRdReq;
    logic       eSel;
    logic [1:0] eURdy;
    logic [1:0] eRv;
    logic [1:0] eRl;
    logic       ePerr;
  } vec_t;

  vec_t tbl [17];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clearInputs();
    u_rd_req = '0; u_rd_type = '0; u_rd_addr = '0;
    u_wr_req = 1'b0; u_wr_type = '0; u_wr_addr = '0; u_wr_wstrb = '0; u_wr_data = '0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
    wr_rdy = 1'b0; wr_done = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    resetn = 1'b0;
    repeat (3) nextCycle();
    resetn = 1'b1;
  endtask

  task automatic setRd(input int i, input logic req, input logic [31:0] addr, input logic [2:0] t);
    u_rd_req[i]          = req;
    u_rd_addr[i*32 +: 32] = addr;
    u_rd_type[i*3 +: 3]   = t;
  endtask

  task automatic applyStimulus(input vec_t v);
    u_rd_req  = v.rq;
    rd_rdy    = v.rdRdy;
    ret_valid = v.rv;
    ret_last  = v.rl;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/rd_req"},      64'(rd_req),      64'(0));
    checkOutput({tag, "/rd_type"},     64'(rd_type),     64'(0));
    checkOutput({tag, "/rd_addr"},     64'(rd_addr),     64'(0));
    checkOutput({tag, "/u_rd_rdy"},    64'(u_rd_rdy),    64'(0));
    checkOutput({tag, "/u_ret_valid"}, 64'(u_ret_valid), 64'(0));
    checkOutput({tag, "/u_ret_last"},  64'(u_ret_last),  64'(0));
    checkOutput({tag, "/u_ret_data"},  64'(u_ret_data),  64'(0));
    checkOutput({tag, "/u_wr_rdy"},    64'(u_wr_rdy),    64'(0));
    checkOutput({tag, "/wr_req"},      64'(wr_req),      64'(0));
    checkOutput({tag, "/proto_err"},   64'(proto_err),   64'(0));
  endtask

  function automatic logic [26:0] lineOf(input logic [31:0] a);
    return a[31:5];
  endfunction

  function automatic logic [2:0] normType(input logic [2:0] t);
    return (t == 3'b100) ? 3'b100 : 3'b010;
  endfunction

  function automatic int beatsFor(input logic [2:0] t);
    return (t == 3'b100) ? LWORDS : 1;
  endfunction

  // Transaction-level reference state for the randomized run.
  int          mOwner;
  bit          mAddrDone;
  logic [31:0] mAddr;
  logic [2:0]  mType;
  int          mBeats;
  int          mTarget;
  int          mRr;
  bit          mWrBusy;
  logic [26:0] mPend;
  bit          mPerr;

  bit          rqAct [N];
  logic [31:0] rqA [N];
  logic [2:0]  rqT [N];
  bit          wAct;
  int          doneCnt;
  logic [31:0] pool [5];
  logic [2:0]  typePool [3];

  initial begin
    logic [31:0] vecAddr [2];
    logic        wrHs;
    logic [N-1:0] haz;
    logic [N-1:0] expRdy, expRv, expRl;

    pool[0] = 32'h1C000000; pool[1] = 32'h1C000020; pool[2] = 32'h00001000;
    pool[3] = 32'h00001014; pool[4] = 32'h00002000;
    typePool[0] = 3'b010; typePool[1] = 3'b100; typePool[2] = 3'b011;

    // rq_rdRdy.rv.rl_eRdReq.eSel_eURdy_eRv_eRl_ePerr
    tbl[0]  = vec_t'(14'b11_000_00_00_00_00_0);
    tbl[1]  = vec_t'(14'b11_100_10_01_00_00_0);
    tbl[2]  = vec_t'(14'b11_011_00_00_01_01_0);
    tbl[3]  = vec_t'(14'b11_000_00_00_00_00_0);
    tbl[4]  = vec_t'(14'b11_000_11_00_00_00_0);
    tbl[5]  = vec_t'(14'b11_100_11_10_00_00_0);
    tbl[6]  = vec_t'(14'b11_000_00_00_00_00_0);
    tbl[7]  = vec_t'(14'b11_011_00_00_10_10_0);
    tbl[8]  = vec_t'(14'b11_000_00_00_00_00_0);
    tbl[9]  = vec_t'(14'b11_100_10_01_00_00_0);
    tbl[10] = vec_t'(14'b11_010_00_00_01_00_0);
    tbl[11] = vec_t'(14'b11_011_00_00_01_01_0);
    tbl[12] = vec_t'(14'b11_000_00_00_00_00_1);
    tbl[13] = vec_t'(14'b11_100_11_10_00_00_1);
    tbl[14] = vec_t'(14'b11_011_00_00_10_10_1);
    tbl[15] = vec_t'(14'b00_000_00_00_00_00_1);
    tbl[16] = vec_t'(14'b00_000_00_00_00_00_1);

    doReset();
    settle();
    checkAllZero("reset");
    nextCycle();

    // Round-robin alternation and a word read returning two beats.
    vecAddr[0] = 32'h1C000000;
    vecAddr[1] = 32'h00003000;
    setRd(0, 1'b0, vecAddr[0], 3'b010);
    setRd(1, 1'b0, vecAddr[1], 3'b010);
    for (int r = 0; r < 17; r++) begin
      applyStimulus(tbl[r]);
      settle();
      checkOutput($sformatf("tbl%0d/rd_req", r),      64'(rd_req),      64'(tbl[r].eRdReq));
      checkOutput($sformatf("tbl%0d/u_rd_rdy", r),    64'(u_rd_rdy),    64'(tbl[r].eURdy));
      checkOutput($sformatf("tbl%0d/u_ret_valid", r), 64'(u_ret_valid), 64'(tbl[r].eRv));
      checkOutput($sformatf("tbl%0d/u_ret_last", r),  64'(u_ret_last),  64'(tbl[r].eRl));
      checkOutput($sformatf("tbl%0d/proto_err", r),   64'(proto_err),   64'(tbl[r].ePerr));
      if (tbl[r].eRdReq)
        checkOutput($sformatf("tbl%0d/rd_addr", r), 64'(rd_addr), 64'(vecAddr[tbl[r].eSel]));
      nextCycle();
    end

    // Single icache line read.
    doReset();
    setRd(0, 1'b1, 32'h1C000020, 3'b100);
    settle();
    checkOutput("line/rd_req_arb", 64'(rd_req), 64'(0));
    nextCycle();
    rd_rdy = 1'b1;
    settle();
    checkOutput("line/rd_req", 64'(rd_req), 64'(1));
    checkOutput("line/rd_addr", 64'(rd_addr), 64'(32'h1C000020));
    checkOutput("line/rd_type", 64'(rd_type), 64'(3'b100));
    checkOutput("line/u_rd_rdy", 64'(u_rd_rdy), 64'(2'b01));
    nextCycle();
    u_rd_req = '0;
    rd_rdy   = 1'b0;
    for (int k = 0; k < LWORDS; k++) begin
      ret_valid = 1'b1;
      ret_last  = (k == LWORDS - 1);
      ret_data  = 32'hA000 + 32'(k);
      settle();
      checkOutput($sformatf("line/u_ret_valid%0d", k), 64'(u_ret_valid), 64'(2'b01));
      checkOutput($sformatf("line/u_ret_last%0d", k), 64'(u_ret_last), (k == LWORDS - 1) ? 64'(1) : 64'(0));
      checkOutput($sformatf("line/u_ret_data%0d", k), 64'(u_ret_data), 64'(32'hA000 + k));
      nextCycle();
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    settle();
    checkOutput("line/proto_err", 64'(proto_err), 64'(0));
    checkOutput("line/idle_valid", 64'(u_ret_valid), 64'(0));
    nextCycle();

    // Write hazard: dcache read of the written line waits, icache read proceeds.
    doReset();
    u_wr_req = 1'b1; u_wr_addr = 32'h00001000; u_wr_type = 3'b100; wr_rdy = 1'b1;
    setRd(0, 1'b1, 32'h1C000000, 3'b010);
    setRd(1, 1'b1, 32'h00001014, 3'b010);
    settle();
    checkOutput("haz/u_wr_rdy", 64'(u_wr_rdy), 64'(1));
    checkOutput("haz/wr_req", 64'(wr_req), 64'(1));
    checkOutput("haz/wr_addr", 64'(wr_addr), 64'(32'h00001000));
    nextCycle();
    u_wr_req = 1'b0;
    rd_rdy   = 1'b1;
    settle();
    checkOutput("haz/ic_rd_addr", 64'(rd_addr), 64'(32'h1C000000));
    checkOutput("haz/ic_u_rd_rdy", 64'(u_rd_rdy), 64'(2'b01));
    checkOutput("haz/pend_u_wr_rdy", 64'(u_wr_rdy), 64'(0));
    nextCycle();
    u_rd_req[0] = 1'b0;
    rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1;
    settle();
    checkOutput("haz/ic_ret", 64'(u_ret_valid), 64'(2'b01));
    nextCycle();
    ret_valid = 1'b0; ret_last = 1'b0;
    u_wr_req = 1'b1; u_wr_addr = 32'h00002000; u_wr_type = 3'b010; u_wr_wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      settle();
      checkOutput($sformatf("haz/stall%0d", k), 64'(rd_req), 64'(0));
      checkOutput($sformatf("haz/wr2_rdy%0d", k), 64'(u_wr_rdy), 64'(0));
      checkOutput($sformatf("haz/wr2_req%0d", k), 64'(wr_req), 64'(0));
      nextCycle();
    end
    wr_done = 1'b1;
    settle();
    checkOutput("haz/done_rd_req", 64'(rd_req), 64'(0));
    checkOutput("haz/done_wr_req", 64'(wr_req), 64'(0));
    nextCycle();
    wr_done = 1'b0;
    settle();
    checkOutput("haz/arb_rd_req", 64'(rd_req), 64'(0));
    checkOutput("haz/wr2_accept", 64'(u_wr_rdy), 64'(1));
    checkOutput("haz/wr2_addr", 64'(wr_addr), 64'(32'h00002000));
    nextCycle();
    u_wr_req = 1'b0;
    rd_rdy = 1'b1;
    settle();
    checkOutput("haz/dc_rd_req", 64'(rd_req), 64'(1));
    checkOutput("haz/dc_rd_addr", 64'(rd_addr), 64'(32'h00001014));
    checkOutput("haz/dc_u_rd_rdy", 64'(u_rd_rdy), 64'(2'b10));
    nextCycle();

    // Reset during the third beat of a line read.
    doReset();
    setRd(1, 1'b1, 32'h1C000040, 3'b100);
    settle();
    nextCycle();
    rd_rdy = 1'b1;
    settle();
    checkOutput("rst/u_rd_rdy", 64'(u_rd_rdy), 64'(2'b10));
    nextCycle();
    rd_rdy = 1'b0; u_rd_req = '0; ret_valid = 1'b1; ret_data = 32'hDEAD0001;
    repeat (2) begin settle(); nextCycle(); end
    resetn = 1'b0;
    settle();
    checkOutput("rst/beat3", 64'(u_ret_valid), 64'(2'b10));
    nextCycle();
    resetn = 1'b1;
    settle();
    checkAllZero("rst");
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      ret_last = (k == 4);
      settle();
      checkOutput($sformatf("rst/stray_valid%0d", k), 64'(u_ret_valid), 64'(0));
      checkOutput($sformatf("rst/stray_last%0d", k), 64'(u_ret_last), 64'(0));
      nextCycle();
    end

    // Randomized traffic against the reference model.
    doReset();
    mOwner = -1; mAddrDone = 0; mAddr = '0; mType = '0; mBeats = 0; mTarget = 0;
    mRr = 0; mWrBusy = 0; mPend = '0; mPerr = 0;
    wAct = 0; doneCnt = 0;
    for (int i = 0; i < N; i++) begin rqAct[i] = 0; rqA[i] = pool[0]; rqT[i] = 3'b010; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!rqAct[i] && $urandom_range(0, 3) == 0) begin
          rqAct[i] = 1;
          rqA[i] = pool[$urandom_range(0, 4)];
          rqT[i] = typePool[$urandom_range(0, 2)];
        end
        setRd(i, rqAct[i], rqA[i], rqT[i]);
      end
      rd_rdy    = ($urandom_range(0, 2) != 0);
      ret_data  = $urandom;
      ret_valid = 1'b0;
      ret_last  = 1'b0;
      if (mOwner >= 0 && mAddrDone) begin
        ret_valid = 1'($urandom_range(0, 1));
        ret_last  = ret_valid && (mBeats + 1 == mTarget);
      end
      if (!wAct && $urandom_range(0, 5) == 0) begin
        wAct = 1;
        u_wr_addr  = pool[$urandom_range(0, 4)];
        u_wr_type  = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100;
        u_wr_wstrb = 4'($urandom);
        for (int w = 0; w < LWORDS; w++) u_wr_data[w*32 +: 32] = $urandom;
      end
      u_wr_req = wAct;
      wr_rdy   = 1'($urandom_range(0, 1));
      wr_done  = mWrBusy && (doneCnt == 0);
      settle();

      wrHs = u_wr_req && wr_rdy && !mWrBusy;
      for (int i = 0; i < N; i++)
        haz[i] = (mWrBusy && lineOf(rqA[i]) == mPend) || (wrHs && lineOf(rqA[i]) == lineOf(u_wr_addr));
      expRdy = '0; expRv = '0; expRl = '0;
      if (mOwner >= 0 && !mAddrDone && rd_rdy) expRdy[mOwner] = 1'b1;
      if (mOwner >= 0 && mAddrDone) begin
        expRv[mOwner] = ret_valid;
        expRl[mOwner] = ret_last;
      end
      checkOutput("rnd/rd_req", 64'(rd_req), 64'(mOwner >= 0 && !mAddrDone));
      if (mOwner >= 0 && !mAddrDone) begin
        checkOutput("rnd/rd_addr", 64'(rd_addr), 64'(mAddr));
        checkOutput("rnd/rd_type", 64'(rd_type), 64'(normType(mType)));
      end
      checkOutput("rnd/u_rd_rdy", 64'(u_rd_rdy), 64'(expRdy));
      checkOutput("rnd/u_ret_valid", 64'(u_ret_valid), 64'(expRv));
      checkOutput("rnd/u_ret_last", 64'(u_ret_last), 64'(expRl));
      if (mOwner >= 0 && mAddrDone) checkOutput("rnd/u_ret_data", 64'(u_ret_data), 64'(ret_data));
      checkOutput("rnd/u_wr_rdy", 64'(u_wr_rdy), 64'(wr_rdy && !mWrBusy));
      checkOutput("rnd/wr_req", 64'(wr_req), 64'(u_wr_req && !mWrBusy));
      if (!mWrBusy) begin
        checkOutput("rnd/wr_addr", 64'(wr_addr), 64'(u_wr_addr));
        checkOutput("rnd/wr_data", 64'(wr_data == u_wr_data), 64'(1));
      end
      checkOutput("rnd/proto_err", 64'(proto_err), 64'(mPerr));

      if (mOwner < 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mRr + k) % N;
          if (mOwner < 0 && rqAct[idx] && !haz[idx]) begin
            mOwner = idx; mAddrDone = 0; mAddr = rqA[idx]; mType = rqT[idx];
            mRr = (idx + 1) % N;
          end
        end
      end else if (!mAddrDone) begin
        if (rd_rdy) begin
          mAddrDone = 1; mBeats = 0;
          mTarget = beatsFor(mType) + (($urandom_range(0, 9) == 0) ? 1 : 0);
          rqAct[mOwner] = 0;
        end
      end else if (ret_valid) begin
        mBeats++;
        if (ret_last) begin
          if (mBeats != beatsFor(mType)) mPerr = 1;
          mOwner = -1;
        end
      end
      if (wrHs) begin
        wAct = 0; mWrBusy = 1; mPend = lineOf(u_wr_addr);
        doneCnt = $urandom_range(1, 6);
      end else if (wr_done) begin
        mWrBusy = 0;
      end else if (mWrBusy) begin
        doneCnt--;
      end
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
